// File: rtl/hilo_md_unit_pkg.sv
// Shared command codes, FSM encoding and small arithmetic helpers for the
// HI/LO multiply-divide unit.
package hilo_md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Setup cycle + one cycle per quotient bit + sign fix-up cycle.
  localparam int DIV_LAT = 34;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_SETUP,
    S_DIV_ITER,
    S_DIV_FIX
  } state_t;

  function automatic logic op_valid(input logic [2:0] op);
    return op <= MD_MTLO;
  endfunction

  function automatic logic [63:0] ext64(input logic [31:0] x, input logic sgn);
    return {{32{sgn & x[31]}}, x};
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/hilo_md_unit_div_iter.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first.
// Sign handling and divide-by-zero policy live in the parent.
module md_div_iter
  import hilo_md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [4:0]  cnt;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] d;
  logic [32:0] trial;

  // Shift the next dividend bit into the partial remainder and try the subtract.
  assign trial = {r, q[31]} - {1'b0, d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
      d    <= '0;
    end else if (start) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values and the shift/subtract stays one step per edge.
      busy <= 1'b1;
      cnt  <= 5'(DIV_LAT - 3);
      q    <= dividend;
      r    <= '0;
      d    <= divisor;
    end else if (busy) begin
      r    <= trial[32] ? {r[30:0], q[31]} : trial[31:0];
      q    <= {q[30:0], ~trial[32]};
      cnt  <= cnt - 5'd1;
      if (cnt == 5'd0) busy <= 1'b0;
    end
  end

  // High during the cycle whose closing edge retires the last quotient bit.
  assign done      = busy && (cnt == 5'd0);
  assign quotient  = q;
  assign remainder = r;

endmodule

// File: rtl/hilo_md_unit.sv
// Execute-stage HI/LO owner: MTHI/MTLO in one edge, MULT/MULTU with a fixed
// latency countdown, DIV/DIVU through the iterative divider with sign fix-up.
module hilo_md_unit
  import hilo_md_unit_pkg::*;
#(
  parameter int MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        cmd_drop
);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  count;
  logic [63:0] product;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic        signed_div;
  logic        q_neg;
  logic        r_neg;
  logic        div_zero;
  logic        op_ok;
  logic        accept;
  logic        is_div;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  assign op_ok    = op_valid(md_op);
  assign busy     = (state != S_IDLE);
  assign accept   = start && op_ok && !busy;
  assign cmd_drop = start && op_ok && busy;
  assign is_div   = (md_op == MD_DIV);

  md_div_iter u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (mag32(a_reg, signed_div)),
    .divisor   (mag32(b_reg, signed_div)),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_nx  = state;
    div_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (md_op == MD_MULT || md_op == MD_MULTU)    state_nx = S_MUL;
          else if (md_op == MD_DIV || md_op == MD_DIVU) state_nx = S_DIV_SETUP;
        end
      end
      S_MUL:       if (count == 4'd0) state_nx = S_IDLE;
      S_DIV_SETUP: begin
        div_start = 1'b1;
        state_nx  = S_DIV_ITER;
      end
      // An idle divider here can only mean a lost start; never hang the pipe.
      S_DIV_ITER:  if (div_done || !div_busy) state_nx = S_DIV_FIX;
      S_DIV_FIX:   state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the product and operand latches are reset along with HI/LO so an
      // aborted operation leaves nothing behind that a later command could expose.
      hi         <= '0;
      lo         <= '0;
      done       <= 1'b0;
      count      <= '0;
      product    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_div <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (md_op)
              MD_MTHI: hi <= src_a;
              MD_MTLO: lo <= src_a;
              MD_MULT, MD_MULTU: begin
                product <= ext64(src_a, md_op == MD_MULT) * ext64(src_b, md_op == MD_MULT);
                count   <= 4'(MUL_LAT - 1);
              end
              MD_DIV, MD_DIVU: begin
                a_reg      <= src_a;
                b_reg      <= src_b;
                signed_div <= is_div;
                q_neg      <= is_div && (src_a[31] ^ src_b[31]);
                r_neg      <= is_div && src_a[31];
                div_zero   <= (src_b == 32'd0);
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (count == 4'd0) begin
            {hi, lo} <= product;
            done     <= 1'b1;
          end else begin
            count <= count - 4'd1;
          end
        end
        S_DIV_FIX: begin
          // Divide by zero reports all-ones quotient and the untouched dividend.
          if (div_zero) begin
            lo <= 32'hFFFF_FFFF;
            hi <= a_reg;
          end else begin
            lo <= q_neg ? -div_q : div_q;
            hi <= r_neg ? -div_r : div_r;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hilo_md_unit.md
Name: hilo_md_unit

Overview:
- Execute-stage responder for the multiply/divide/HI-LO-write commands issued by the instruction decoder: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Owns the HI and LO architectural registers and runs multi-cycle operations, indicating progress with a busy/done handshake.
- The hazard logic stalls decode on busy, so the decoder's single-cycle command stream maps onto this multi-cycle engine.

Parameters:
- MUL_LAT, 5, cycles from command acceptance to HI/LO update for MULT/MULTU; legal range 1..16.
- DIV_LAT, 34 (fixed, not overridable), cycles for DIV/DIVU: 1 setup, 32 iterations, 1 sign fix-up.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  command valid from the execute stage; one-cycle pulse per command.
- md_op  in  3  command code (package constants).
- src_a  in  32  rs operand.
- src_b  in  32  rt operand.
- busy  out  1  a MULT/MULTU/DIV/DIVU is in flight.
- done  out  1  one-cycle pulse in the cycle after HI/LO take a multi-cycle result.
- hi  out  32  HI register (read by MFHI).
- lo  out  32  LO register (read by MFLO).
- cmd_drop  out  1  one-cycle pulse: start arrived while busy and was discarded.

Behaviour:
- Reset (rst_n=0, any time, including mid-operation): hi=0, lo=0, busy=0, done=0, cmd_drop=0; FSM to IDLE; in-flight result discarded.
- FSM states: IDLE, MUL, DIV_SETUP, DIV_ITER, DIV_FIX.
- IDLE, start=1, MTHI: hi<=src_a at that edge. busy stays 0, no done pulse.
- IDLE, start=1, MTLO: lo<=src_a at that edge. busy stays 0, no done pulse.
- IDLE, start=1, MULT/MULTU:
  - latch the 64-bit product: signed for MULT, unsigned for MULTU.
  - go to MUL, load the countdown with MUL_LAT-1, busy<=1.
  - when the count reaches 0: {hi,lo}<=product, busy<=0, done<=1 next cycle, back to IDLE.
  - total: busy high for exactly MUL_LAT cycles.
- IDLE, start=1, DIV/DIVU: DIV_SETUP, one cycle.
  - latch magnitudes of the operands (DIV) or raw operands (DIVU).
  - latch quotient/remainder sign flags.
  - then DIV_ITER: 32 restoring-division iterations, 1 quotient bit per cycle, iteration counter 5 bits, from 31 down to 0.
  - then DIV_FIX: apply signs (quotient negative iff operand signs differ; remainder takes the dividend's sign); lo<=quotient, hi<=remainder; busy<=0; done pulse.
  - total: busy high for 34 cycles.
- Divide by zero (src_b=0, DIV or DIVU): runs the full 34 cycles, then lo=32'hFFFF_FFFF, hi=src_a.
- DIV of 32'h8000_0000 by 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- start while busy: command ignored, cmd_drop=1 for that cycle, in-flight operation unaffected. This includes MTHI/MTLO.
- start with an undefined md_op: no effect, no cmd_drop.
- hi/lo outputs are registers only; no bypass of an in-flight result. The MFHI/MFLO hazard is resolved by the stall on busy.
- done and a new start in the same cycle: the start is accepted (FSM is in IDLE).

Decomposition:
- Shared package or define file:
  - md_op codes: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - FSM state encodings.
  - constant DIV_LAT=34.
- Sub-module md_div_iter: the iterative unsigned restoring divider, with start/busy/done and quotient/remainder outputs. The parent does the sign handling.
- Multiply: behavioural `*` plus the latency counter in the parent.

Test Plan:
- MTHI src_a=32'h1234_5678, then MTLO src_a=32'hDEAD_BEEF -> hi/lo show the values one cycle after each edge; busy never 1.
- MULT with src_a=-3, src_b=7 -> busy high 5 cycles; {hi,lo}=64'hFFFF_FFFF_FFFF_FFEB; done pulses once.
- MULTU with 32'hFFFF_FFFF × 32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- DIV -7 / 2 -> busy 34 cycles; lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIVU 100 / 0 -> lo=32'hFFFF_FFFF, hi=100.
- DIVU 100 / 7 -> lo=14, hi=2.
- During that DIVU, MTLO at cycle 10 -> cmd_drop=1 and the DIVU result is unchanged.
- rst_n low at cycle 20 of a DIV -> busy=0, hi=lo=0 immediately; a following MULTU 6×7 gives lo=42.
